// File: rtl/rv_div_unit.sv
// rv_div_unit: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN: resolve divide-by-zero and signed overflow on accept.
module rv_div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            reset,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_dvsr;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic [4:0]       r_rd_addr;
  logic             r_busy;
  logic             r_valid;
  logic [XLEN-1:0]  r_result;
  logic [4:0]       r_rd_out;

  // Operand decode at the accepting edge
  logic            w_accept;
  logic            w_in_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_in_div_zero;
  logic            w_early;

  assign w_accept      = start_i & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_in_signed   = ~op_i[0];
  assign w_a_neg       = w_in_signed & rs1_data_i[XLEN-1];
  assign w_b_neg       = w_in_signed & rs2_data_i[XLEN-1];
  assign w_a_mag       = w_a_neg ? (~rs1_data_i + XLEN'(1)) : rs1_data_i;
  assign w_b_mag       = w_b_neg ? (~rs2_data_i + XLEN'(1)) : rs2_data_i;
  assign w_in_div_zero = (rs2_data_i == '0);

`ifdef DIV_EARLY_OUT_EN
  logic            w_in_ovf;
  logic [XLEN-1:0] w_special_res;

  assign w_in_ovf = w_in_signed & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                  & (rs2_data_i == {XLEN{1'b1}});
  assign w_early  = w_in_div_zero | w_in_ovf;
  // Overflow quotient equals the dividend itself (most negative value)
  assign w_special_res = w_in_div_zero ? (op_i[1] ? rs1_data_i : {XLEN{1'b1}})
                                       : (op_i[1] ? '0 : rs1_data_i);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: trial-subtract divisor from the shifted partial remainder
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quo_next;

  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign w_ge       = ~w_diff[XLEN];
  assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_ge};

  // Sign correction and output selection
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;

  assign w_quo_fix = r_div_zero ? {XLEN{1'b1}}
                                : (r_neg_q ? (~r_quo + XLEN'(1)) : r_quo);
  assign w_rem_fix = r_neg_r ? (~r_rem + XLEN'(1)) : r_rem;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next_state = w_early ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(XLEN-1)) w_next_state = S_FIX;
      end
      S_FIX: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        if (start_i) w_next_state = w_early ? S_DONE : S_CALC;
        else         w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvsr     <= '0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_rd_out   <= '0;
    end else begin
      r_busy  <= (w_next_state == S_CALC) | (w_next_state == S_FIX);
      r_valid <= (w_next_state == S_DONE);
      if (w_accept) begin
        r_cnt      <= '0;
        r_rem      <= '0;
        r_quo      <= w_a_mag;
        r_dvsr     <= w_b_mag;
        r_is_rem   <= op_i[1];
        r_neg_q    <= w_in_signed & (rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1]);
        r_neg_r    <= w_a_neg;
        r_div_zero <= w_in_div_zero;
        r_rd_addr  <= rd_addr_i;
`ifdef DIV_EARLY_OUT_EN
        if (w_early) begin
          r_result <= w_special_res;
          r_rd_out <= rd_addr_i;
        end
`endif
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
      end else if (r_state == S_FIX) begin
        r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
        r_rd_out <= r_rd_addr;
      end
    end
  end

  assign busy_o    = r_busy;
  assign valid_o   = r_valid;
  assign result_o  = r_result;
  assign rd_addr_o = r_rd_out;

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit against an arithmetic reference model.
module tb_rv_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int tests_run    = 0;
  int tests_failed = 0;

  rv_div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk_i      (clk_i),
    .reset      (reset),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  always #5 clk_i = ~clk_i;

  // RISC-V M semantics with wide integer arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    sa = op[0] ? longint'(a) : longint'($signed(a));
    sb = op[0] ? longint'(b) : longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic scramble_inputs();
    op_i       = 2'($urandom);
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    rd_addr_i  = 5'($urandom);
  endtask

  // Issue one operation and check latency, busy span, result, rd and pulse width
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit mid_pulse, input string name);
    logic [31:0] exp;
    int lat_exp, busy_exp, n, busy_cnt;
    bit got;
    exp      = ref_result(op, a, b);
    lat_exp  = (EARLY && is_special(op, a, b)) ? 1 : 33;
    busy_exp = (lat_exp == 1) ? 0 : 33;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    scramble_inputs();
    n = 0; busy_cnt = 0; got = 1'b0;
    if (busy_o) busy_cnt++;
    while (n < 100 && !got) begin
      @(posedge clk_i); #1;
      n++;
      if (mid_pulse && n == 5) begin start_i = 1'b1; scramble_inputs(); end
      if (mid_pulse && n == 6) start_i = 1'b0;
      if (valid_o) got = 1'b1;
      else if (busy_o) busy_cnt++;
    end
    start_i = 1'b0;
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL %s timeout: valid_o not seen within %0d edges", name, n);
      return;
    end
    tests_run++;
    if (n !== lat_exp || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d edges busy=%b, expected %0d busy=0", name, n, busy_o, lat_exp);
    end
    tests_run++;
    if (result_o !== exp || rd_addr_o !== rd) begin
      tests_failed++;
      $display("FAIL %s result: got %h rd=%0d, expected %h rd=%0d", name, result_o, rd_addr_o, exp, rd);
    end
    tests_run++;
    if (busy_cnt !== busy_exp) begin
      tests_failed++;
      $display("FAIL %s busy span: got %0d cycles, expected %0d", name, busy_cnt, busy_exp);
    end
    @(posedge clk_i); #1;
    tests_run++;
    if (valid_o !== 1'b0 || result_o !== exp || rd_addr_o !== rd) begin
      tests_failed++;
      $display("FAIL %s hold: valid=%b result=%h rd=%0d, expected valid=0 result=%h rd=%0d",
               name, valid_o, result_o, rd_addr_o, exp, rd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; op_i = 2'd0; rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    tests_run++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'd0 || rd_addr_o !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b valid=%b result=%h rd=%0d, expected all 0",
               busy_o, valid_o, result_o, rd_addr_o);
    end
    @(negedge clk_i);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    do_op(2'b01, 32'd100, 32'd7, 5'd5, 1'b0, "divu_100_7");
    do_op(2'b11, 32'd100, 32'd7, 5'd5, 1'b0, "remu_100_7");
    do_op(2'b00, -32'sd20, 32'd3, 5'd1, 1'b0, "div_m20_3");
    do_op(2'b10, -32'sd20, 32'd3, 5'd2, 1'b0, "rem_m20_3");
    do_op(2'b10, 32'd20, -32'sd3, 5'd3, 1'b0, "rem_20_m3");
    do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b0, "divu_max_1");
    do_op(2'b01, 32'd5, 32'hFFFF_FFFF, 5'd6, 1'b0, "divu_5_max");
    do_op(2'b11, 32'd5, 32'hFFFF_FFFF, 5'd0, 1'b0, "remu_5_max_x0");
  endtask

  task automatic test_special();
    do_op(2'b00, 32'd123, 32'd0, 5'd7, 1'b0, "div_by_zero");
    do_op(2'b11, 32'd123, 32'd0, 5'd8, 1'b0, "remu_by_zero");
    do_op(2'b10, -32'sd77, 32'd0, 5'd9, 1'b0, "rem_neg_by_zero");
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0, "div_overflow");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, "rem_overflow");
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0, "divu_not_overflow");
  endtask

  task automatic test_mid_pulse();
    do_op(2'b00, 32'd1000, -32'sd7, 5'd13, 1'b1, "mid_calc_pulse");
  endtask

  task automatic test_back_to_back();
    int n;
    bit got;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; rs1_data_i = 32'd50; rs2_data_i = 32'd5; rd_addr_i = 5'd14;
    @(posedge clk_i); #1;
    rs1_data_i = 32'd9; rs2_data_i = 32'd2; rd_addr_i = 5'd15;
    for (int k = 0; k < 2; k++) begin
      n = 0; got = 1'b0;
      while (n < 100 && !got) begin
        @(posedge clk_i); #1;
        n++;
        if (valid_o) got = 1'b1;
      end
      tests_run++;
      if (!got || n !== 33 || result_o !== (k == 0 ? 32'd10 : 32'd4)
          || rd_addr_o !== (k == 0 ? 5'd14 : 5'd15)) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got=%b edges=%0d result=%h rd=%0d, expected 33 edges result=%h",
                 k, got, n, result_o, rd_addr_o, (k == 0 ? 32'd10 : 32'd4));
      end
      if (k == 0) begin
        @(posedge clk_i); #1;
        start_i = 1'b0;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; rs1_data_i = 32'd999; rs2_data_i = 32'd3; rd_addr_i = 5'd16;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'd0 || rd_addr_o !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_op: busy=%b valid=%b result=%h rd=%0d, expected all 0",
               busy_o, valid_o, result_o, rd_addr_o);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_valid: valid_o pulsed=%b after abort, expected 0", seen);
    end
    do_op(2'b01, 32'd8, 32'd2, 5'd17, 1'b0, "divu_after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  op;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(1, 15));
        1: b = -32'($urandom_range(1, 15));
        2: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      do_op(op, a, b, 5'($urandom), (i % 7) == 3, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_mid_pulse();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rv_div_unit.md
Name: rv_div_unit

Overview:
- Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions, in the execute stage directly downstream of the register file.
- Consumes the two RF read-port values as operands.
- Produces a 32-bit result plus destination register address that drive the RF write port (wd/addr3/we).
- busy_o stalls the pipeline while a division is in flight.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= XLEN.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  request a division; sampled only when the block accepts (IDLE or DONE).
- op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; latched on accept.
- rs1_data_i  input  XLEN  dividend (from RF rd1_o); latched on accept.
- rs2_data_i  input  XLEN  divisor (from RF rd2_o); latched on accept.
- rd_addr_i  input  5  destination register; latched on accept.
- busy_o  output  1  high in CALC and FIX; pipeline stall.
- valid_o  output  1  one-cycle pulse, high in DONE; RF write enable.
- result_o  output  XLEN  quotient or remainder; held stable from DONE until the next DONE.
- rd_addr_o  output  5  latched rd_addr_i; held alongside result_o.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; busy_o=0; valid_o=0; result_o=0; rd_addr_o=0; counter=0; all internal operand/remainder registers=0.
- Reset mid-operation aborts the division with no valid_o pulse. After reset deasserts, the first rising edge with start_i=1 is accepted.

States:
- IDLE: start_i=1 -> latch op, operands and rd_addr; compute magnitudes (abs for signed ops, raw for unsigned); go to CALC with counter=0. Otherwise stay in IDLE.
- CALC: one restoring-division step per cycle.
  - Shift {rem,quo} left 1; if rem >= |divisor|, subtract and set quo LSB.
  - Counter increments each cycle; after XLEN steps (counter==XLEN-1 at the edge) go to FIX.
- FIX: apply sign correction and select the output, register it into result_o/rd_addr_o, go to DONE.
  - Quotient is negated when signed and the operand signs differ.
  - Remainder takes the dividend's sign.
- DONE: valid_o=1 for exactly this cycle, busy_o=0.
  - start_i=1 -> accept a new operation and go directly to CALC (back-to-back).
  - Otherwise go to IDLE.

Latency and handshake:
- Accept at edge E0. CALC occupies the cycles after E0..E31; FIX follows E32; DONE follows E33.
- valid_o is visible 33 edges after acceptance.
- start_i in CALC or FIX is ignored; it is not queued.
- Input operands may change freely after the accepting edge.

Arithmetic (RISC-V defined, no traps):
- Divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend unchanged.
- Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Magnitude of 0x80000000 is handled as unsigned 0x80000000, i.e. computed at XLEN width with no sign bit lost.

Other rules:
- rd_addr_i==0 is processed normally and valid_o still pulses; the RF discards writes to x0.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow cases are detected in IDLE/DONE on accept.
  - The block skips CALC and FIX, loads the special result directly, and enters DONE on the next edge.
  - valid_o appears 1 edge after acceptance; busy_o never asserts for these cases.
- Undefined: these cases run the full 33-edge sequence and produce identical values at the normal latency.

Test Plan:
- DIVU 100/7, rd=5: start_i one cycle -> busy_o high for 33 cycles, then valid_o one cycle with result_o=14 and rd_addr_o=5; REMU same operands -> 2.
- DIV -20/3 -> 0xFFFFFFFA (-6); REM -20/3 -> 0xFFFFFFFE (-2); REM 20/-3 -> 2.
- Divisor 0: DIV 123/0 -> 0xFFFFFFFF; REMU 123/0 -> 123. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Latency is 33 edges without the macro and 1 edge with DIV_EARLY_OUT_EN.
- Back-to-back: hold start_i=1 with DIVU 50/5 and then DIVU 9/2 presented in DONE -> valid_o pulses 33 edges apart with results 10 then 4. A start_i pulse mid-CALC changes neither the result nor the timing.
- Reset: assert reset 10 cycles into a DIV -> all outputs 0 immediately; no valid_o pulse; a new DIVU 8/2 after release -> 4.
- Max values: DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; DIVU 5/0xFFFFFFFF -> 0; REMU 5/0xFFFFFFFF -> 5.
